param_mem: RTL and testbench
============================

Name: param_mem

Overview:
Parametrised single-port synchronous data/instruction memory for the CPU. It replaces the fixed 16x16 store with configurable width and depth. After reset it runs a hardware clear sequence and loads a boot word. Reads are registered, with a read-valid strobe. Out-of-range accesses are flagged and never corrupt storage.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, address bus width in bits
DEPTH, 16, number of words; must satisfy 2 <= DEPTH <= 2^ADDR_W
BOOT_ADDR, 0, word address loaded with BOOT_WORD after clear; must be < DEPTH
BOOT_WORD, 16'b0010011111100111, initial instruction (R1 = R1 + 4'b1111), DATA_W bits

Ports:
CLK  input  1  system clock; all state changes on rising edge
reset  input  1  reset, synchronous, active-high
MemRead  input  1  read request, sampled at rising edge
MemWrite  input  1  write request, sampled at rising edge
ADDR  input  ADDR_W  word address for read/write
Data_in  input  DATA_W  write data
Data_out  output  DATA_W  registered read data
rd_valid  output  1  one-cycle strobe: Data_out updated by a read
busy  output  1  high while clear/boot sequence runs; requests ignored
addr_err  output  1  one-cycle strobe: last accepted request had ADDR >= DEPTH

Behaviour:
- States: CLEAR, BOOT, READY. A clear pointer clr_ptr holds values 0..DEPTH-1.
- Reset (edge with reset=1): state=CLEAR, clr_ptr=0, Data_out=0, rd_valid=0, addr_err=0, busy=1. Memory array is not touched on reset edges.
- Reset dominates. Asserting reset in any state, including mid-CLEAR or mid-BOOT, restarts the sequence from clr_ptr=0.
- CLEAR: each edge writes 0 to mem[clr_ptr].
  - clr_ptr increments each edge.
  - On the edge that writes mem[DEPTH-1], go to BOOT.
- BOOT: one edge writes BOOT_WORD to mem[BOOT_ADDR], then go to READY.
- busy=1 in CLEAR and BOOT. busy=0 in READY. busy is registered.
- After reset deasserts, busy stays high for exactly DEPTH+1 edges. The first request can be accepted on the next edge.
- While busy=1, MemRead and MemWrite are ignored: no write, rd_valid=0, addr_err=0.
- READY, write: MemWrite=1 with ADDR < DEPTH writes mem[ADDR]=Data_in at the edge.
- READY, read: MemRead=1 with ADDR < DEPTH gives Data_out=mem[ADDR] and rd_valid=1 after the same edge. Latency is 1 cycle.
- rd_valid is a single-cycle strobe per accepted read. Back-to-back reads keep rd_valid high continuously.
- Data_out holds its last value when no read occurs.
- Simultaneous MemRead and MemWrite to the same address: read-first. Data_out returns the old contents and the array takes Data_in.
- Simultaneous read and write to different addresses: both are performed.
- Out of range (ADDR >= DEPTH, full ADDR_W compare, no aliasing or truncation):
  - The write is dropped.
  - A read gives Data_out=0 and rd_valid=1.
  - addr_err=1 for one cycle if either request is out of range.
- No request: rd_valid=0 and addr_err=0 on the next cycle.
- Memory contents are never X after the sequence completes. The RTL infers a synchronous RAM with read-first behaviour.

Test Plan:
1. Boot sequence (defaults): reset=1 for 2 edges, then 0. Required: busy=1 for exactly 17 edges, then 0; read ADDR=0 -> Data_out=16'h27E7, rd_valid=1 one cycle later; read ADDR=5 -> 16'h0000.
2. Write/read: write 16'hBEEF to ADDR=3, next cycle read ADDR=3. Required: Data_out=16'hBEEF, rd_valid high exactly one cycle, addr_err=0; Data_out holds 16'hBEEF afterwards.
3. Read-during-write: mem[7]=16'h1111, then one edge with MemRead=MemWrite=1, ADDR=7, Data_in=16'h2222. Required: Data_out=16'h1111; a following read gives 16'h2222.
4. Out of range: write 16'hAAAA to ADDR=16, then read ADDR=16, then read ADDR=0. Required: addr_err pulses on both requests; read data = 0; mem[0] still 16'h27E7, with no aliasing into word 0.
5. Busy lockout: during CLEAR, write 16'h5555 to ADDR=2 and read ADDR=2. Required: rd_valid=0, addr_err=0; after busy falls, read ADDR=2 -> 16'h0000.
6. Reset mid-operation: write 16'h1234 to ADDR=4 in READY, then assert reset for 1 edge at clr_ptr=5 during a second sequence. Required: busy restarts and lasts 17 edges; read ADDR=4 -> 16'h0000; ADDR=0 -> 16'h27E7. Repeat with DEPTH=64, DATA_W=32: busy lasts 65 edges.

Source files
------------

// File: rtl/param_mem.sv
// Parametrised single-port synchronous data/instruction memory.
// After reset it clears every word, then loads the boot instruction. Reads are registered.
module param_mem #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 16,
    parameter int                BOOT_ADDR = 0,
    parameter logic [DATA_W-1:0] BOOT_WORD = DATA_W'(16'b0010011111100111)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] BOOT_IDX = IDX_W'(BOOT_ADDR);

    typedef enum logic [1:0] {CLEAR, BOOT, READY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q, busy_q, addr_err_q;

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic              rd_accept;
    logic              err_d;

    // Full-width compare so out-of-range addresses can never alias onto a low word.
    assign in_range = ({1'b0, ADDR} < (ADDR_W + 1)'(DEPTH));
    assign idx      = ADDR[IDX_W-1:0];

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        rd_accept = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_ptr_q;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = BOOT;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            BOOT: begin
                we      = 1'b1;
                waddr   = BOOT_IDX;
                wdata   = BOOT_WORD;
                state_d = READY;
            end
            READY: begin
                we        = MemWrite && in_range;
                waddr     = idx;
                wdata     = Data_in;
                rd_accept = MemRead;
                err_d     = (MemRead || MemWrite) && !in_range;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Storage is deliberately left alone on reset edges.
    always_ff @(posedge CLK) begin
        if (!reset && we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first: a same-address write lands after the old word is captured.
    always_ff @(posedge CLK) begin
        if (reset) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            rd_valid_q <= rd_accept;
            addr_err_q <= err_d;
            busy_q     <= (state_d != READY);
            if (rd_accept) begin
                data_out_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    assign Data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_param_mem.sv
// Self-checking bench for param_mem: a default instance against an array reference model,
// plus a 64x32 instance for the longer boot sequence.
module tb_param_mem;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int DEP  = 16;
    localparam int DW2  = 32;
    localparam int DEP2 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, mem_read, mem_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in, data_out;
    logic          rd_valid, busy, addr_err;

    logic           reset2, rd2, wr2;
    logic [AW-1:0]  addr2;
    logic [DW2-1:0] din2, dout2;
    logic           rdv2, busy2, err2;

    param_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
        .CLK(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write),
        .ADDR(addr), .Data_in(data_in), .Data_out(data_out),
        .rd_valid(rd_valid), .busy(busy), .addr_err(addr_err)
    );

    param_mem #(.DATA_W(DW2), .ADDR_W(AW), .DEPTH(DEP2)) dut2 (
        .CLK(clk), .reset(reset2), .MemRead(rd2), .MemWrite(wr2),
        .ADDR(addr2), .Data_in(din2), .Data_out(dout2),
        .rd_valid(rdv2), .busy(busy2), .addr_err(err2)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] ref_mem [DEP];
    logic [DW-1:0] exp_dout;
    logic          exp_rdv, exp_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After a completed sequence every word is zero except the boot word at address 0.
    task automatic model_boot();
        for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
        ref_mem[0] = 16'h27E7;
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        data_in   = d;
        exp_rdv   = rd;
        exp_err   = (rd || wr) && (a >= DEP);
        if (rd) exp_dout = (a < DEP) ? ref_mem[a] : '0;
        if (wr && a < DEP) ref_mem[a] = d;
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        $display("op rd=%0b wr=%0b addr=%h din=%h -> dout=%h rdv=%0b err=%0b", rd, wr, a, d, data_out, rd_valid, addr_err);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rdv got=%b exp=0", rd_valid); else pass_cnt++;
        total_cnt++; if (addr_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", addr_err); else pass_cnt++;
        total_cnt++; if (data_out !== 16'h0000) $display("FAIL reset_dout got=%h exp=0000", data_out); else pass_cnt++;
        // Requests held during the sequence must be ignored.
        mem_read = 1'b1; mem_write = 1'b1; addr = 16'd2; data_in = 16'h5555;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
            total_cnt++;
            if (rd_valid !== 1'b0 || addr_err !== 1'b0)
                $display("FAIL lockout edge=%0d rdv=%b err=%b exp=0/0", n, rd_valid, addr_err);
            else pass_cnt++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        model_boot();
        exp_dout = '0;
        total_cnt++; if (n != DEP + 1) $display("FAIL busy_len got=%0d exp=%0d", n, DEP + 1); else pass_cnt++;
        do_op(1, 0, 16'd0, '0);
        total_cnt++; if (data_out !== 16'h27E7 || rd_valid !== 1'b1) $display("FAIL boot_word got=%h/%b exp=27e7/1", data_out, rd_valid); else pass_cnt++;
        do_op(1, 0, 16'd5, '0);
        total_cnt++; if (data_out !== 16'h0000) $display("FAIL clear_word5 got=%h exp=0000", data_out); else pass_cnt++;
        do_op(1, 0, 16'd2, '0);
        total_cnt++; if (data_out !== 16'h0000) $display("FAIL lockout_word2 got=%h exp=0000", data_out); else pass_cnt++;
        do_op(0, 0, 16'd0, '0);
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL idle_rdv got=%b exp=0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_write_read();
        do_op(0, 1, 16'd3, 16'hBEEF);
        total_cnt++; if (rd_valid !== 1'b0 || addr_err !== 1'b0) $display("FAIL wr_flags got=%b/%b exp=0/0", rd_valid, addr_err); else pass_cnt++;
        do_op(1, 0, 16'd3, '0);
        total_cnt++; if (data_out !== 16'hBEEF || rd_valid !== 1'b1 || addr_err !== 1'b0)
            $display("FAIL wr_rd got=%h/%b/%b exp=beef/1/0", data_out, rd_valid, addr_err); else pass_cnt++;
        do_op(0, 0, 16'd0, '0);
        total_cnt++; if (data_out !== 16'hBEEF || rd_valid !== 1'b0) $display("FAIL hold got=%h/%b exp=beef/0", data_out, rd_valid); else pass_cnt++;
    endtask

    task automatic test_read_during_write();
        do_op(0, 1, 16'd7, 16'h1111);
        do_op(1, 1, 16'd7, 16'h2222);
        total_cnt++; if (data_out !== 16'h1111) $display("FAIL rdw_old got=%h exp=1111", data_out); else pass_cnt++;
        do_op(1, 0, 16'd7, '0);
        total_cnt++; if (data_out !== 16'h2222) $display("FAIL rdw_new got=%h exp=2222", data_out); else pass_cnt++;
        do_op(1, 1, 16'd9, 16'h3333);
        total_cnt++; if (data_out !== ref_mem[7] && exp_dout !== data_out) $display("FAIL rdw_diff got=%h exp=%h", data_out, exp_dout); else pass_cnt++;
        do_op(1, 0, 16'd9, '0);
        total_cnt++; if (data_out !== 16'h3333) $display("FAIL rdw_diff_wr got=%h exp=3333", data_out); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        do_op(0, 1, 16'd16, 16'hAAAA);
        total_cnt++; if (addr_err !== 1'b1 || rd_valid !== 1'b0) $display("FAIL oob_wr got=%b/%b exp=1/0", addr_err, rd_valid); else pass_cnt++;
        do_op(1, 0, 16'd16, '0);
        total_cnt++; if (addr_err !== 1'b1 || rd_valid !== 1'b1 || data_out !== 16'h0000)
            $display("FAIL oob_rd got=%b/%b/%h exp=1/1/0000", addr_err, rd_valid, data_out); else pass_cnt++;
        do_op(1, 0, 16'd0, '0);
        total_cnt++; if (data_out !== 16'h27E7 || addr_err !== 1'b0) $display("FAIL oob_alias got=%h/%b exp=27e7/0", data_out, addr_err); else pass_cnt++;
        do_op(1, 0, 16'd15, '0);
        total_cnt++; if (addr_err !== 1'b0 || data_out !== ref_mem[15]) $display("FAIL top_word got=%b/%h exp=0/%h", addr_err, data_out, ref_mem[15]); else pass_cnt++;
        do_op(0, 1, 16'hFFFF, 16'h9999);
        total_cnt++; if (addr_err !== 1'b1) $display("FAIL oob_ffff got=%b exp=1", addr_err); else pass_cnt++;
        do_op(1, 0, 16'd15, '0);
        total_cnt++; if (data_out !== exp_dout) $display("FAIL oob_ffff_alias got=%h exp=%h", data_out, exp_dout); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEP; i++) do_op(0, 1, AW'(i), DW'($urandom));
        for (int i = 0; i < DEP; i++) begin
            do_op(1, 0, AW'(i), '0);
            total_cnt++;
            if (rd_valid !== 1'b1 || data_out !== exp_dout)
                $display("FAIL b2b addr=%0d got=%h/%b exp=%h/1", i, data_out, rd_valid, exp_dout);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit rd, wr;
            logic [AW-1:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? AW'(16 + $urandom_range(0, 65519)) : AW'($urandom_range(0, 15));
            do_op(rd, wr, a, DW'($urandom));
            total_cnt++;
            if (data_out !== exp_dout || rd_valid !== exp_rdv || addr_err !== exp_err)
                $display("FAIL rand i=%0d got=%h/%b/%b exp=%h/%b/%b", i, data_out, rd_valid, addr_err, exp_dout, exp_rdv, exp_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_op(0, 1, 16'd4, 16'h1234);
        do_op(1, 0, 16'd4, '0);
        total_cnt++; if (data_out !== 16'h1234) $display("FAIL mid_pre got=%h exp=1234", data_out); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++; if (data_out !== 16'h0000 || busy !== 1'b1) $display("FAIL mid_reset got=%h/%b exp=0000/1", data_out, busy); else pass_cnt++;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        model_boot();
        exp_dout = '0;
        total_cnt++; if (n != DEP + 1) $display("FAIL mid_busy_len got=%0d exp=%0d", n, DEP + 1); else pass_cnt++;
        do_op(1, 0, 16'd4, '0);
        total_cnt++; if (data_out !== 16'h0000) $display("FAIL mid_word4 got=%h exp=0000", data_out); else pass_cnt++;
        do_op(1, 0, 16'd0, '0);
        total_cnt++; if (data_out !== 16'h27E7) $display("FAIL mid_word0 got=%h exp=27e7", data_out); else pass_cnt++;
    endtask

    task automatic test_big();
        int n;
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 300) begin
            step();
            n++;
        end
        total_cnt++; if (n != DEP2 + 1) $display("FAIL big_busy_len got=%0d exp=%0d", n, DEP2 + 1); else pass_cnt++;
        rd2 = 1'b1; addr2 = 16'd0; step(); rd2 = 1'b0;
        $display("big rd addr=0 -> dout=%h rdv=%b", dout2, rdv2);
        total_cnt++; if (dout2 !== 32'h000027E7 || rdv2 !== 1'b1) $display("FAIL big_boot got=%h/%b exp=000027e7/1", dout2, rdv2); else pass_cnt++;
        wr2 = 1'b1; addr2 = 16'd63; din2 = 32'hDEADBEEF; step(); wr2 = 1'b0;
        rd2 = 1'b1; step(); rd2 = 1'b0;
        $display("big rd addr=63 -> dout=%h", dout2);
        total_cnt++; if (dout2 !== 32'hDEADBEEF) $display("FAIL big_top got=%h exp=deadbeef", dout2); else pass_cnt++;
        wr2 = 1'b1; addr2 = 16'd64; din2 = 32'h55555555; step(); wr2 = 1'b0;
        total_cnt++; if (err2 !== 1'b1) $display("FAIL big_oob_err got=%b exp=1", err2); else pass_cnt++;
        rd2 = 1'b1; addr2 = 16'd0; step(); rd2 = 1'b0;
        $display("big rd addr=0 -> dout=%h", dout2);
        total_cnt++; if (dout2 !== 32'h000027E7) $display("FAIL big_alias got=%h exp=000027e7", dout2); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; data_in = '0;
        reset2 = 1'b1; rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
        exp_dout = '0; exp_rdv = 1'b0; exp_err = 1'b0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_big();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
